atomrvcore_fetch_queue: RTL and testbench

Instruction fetch queue sitting directly downstream of the instruction fetch unit and upstream of decode. Buffers up to DEPTH {PC, instruction} pairs so fetch keeps running while decode stalls. Provides a valid/ready handshake on both sides. Discards all buffered entries on a taken-branch flush.

---
 rtl/atomrvcore_pkg.sv | 13 +
 rtl/atomrvcore_fetch_queue_if.sv | 29 ++
 rtl/atomrvcore_fq_ram.sv | 27 ++
 rtl/atomrvcore_fetch_queue.sv | 107 ++++++++++
 tb/tb_atomrvcore_fetch_queue.sv | 130 +++++++++++++
 5 files changed

// File: rtl/atomrvcore_pkg.sv
// Shared types and defaults for the atomrvcore fetch queue.
package atomrvcore_pkg;

    localparam int unsigned FQ_DATAWIDTH     = 32;
    localparam int unsigned FQ_DEPTH_DEFAULT = 4;

    // One buffered fetch result: PC plus the instruction word fetched from it.
    typedef struct packed {
        logic [FQ_DATAWIDTH-1:0] pc;
        logic [FQ_DATAWIDTH-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/atomrvcore_fetch_queue_if.sv
// Fetch-side and decode-side handshake bundle of the fetch queue.
// master: the fetch unit / decode environment; slave: the queue itself.
interface atomrvcore_fetch_queue_if #(
    parameter int unsigned DATAWIDTH = atomrvcore_pkg::FQ_DATAWIDTH,
    parameter int unsigned DEPTH     = atomrvcore_pkg::FQ_DEPTH_DEFAULT
);

    logic                         flush_i;
    logic                         valid_i;
    logic [DATAWIDTH-1:0]         PC_i;
    logic [DATAWIDTH-1:0]         instruction_i;
    logic                         ready_o;
    logic                         valid_o;
    logic [DATAWIDTH-1:0]         PC_o;
    logic [DATAWIDTH-1:0]         instruction_o;
    logic                         ready_i;
    logic [$clog2(DEPTH+1)-1:0]   count_o;

    modport master (
        output flush_i, valid_i, PC_i, instruction_i, ready_i,
        input  ready_o, valid_o, PC_o, instruction_o, count_o
    );

    modport slave (
        input  flush_i, valid_i, PC_i, instruction_i, ready_i,
        output ready_o, valid_o, PC_o, instruction_o, count_o
    );

endinterface

// File: rtl/atomrvcore_fq_ram.sv
// Fetch queue storage: DEPTH entries, one write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the pointers.
module atomrvcore_fq_ram
    import atomrvcore_pkg::*;
#(
    parameter int unsigned DEPTH = FQ_DEPTH_DEFAULT
) (
    input  logic                       clk_i,
    input  logic                       we_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr_i,
    input  fq_entry_t                  wdata_i,
    input  logic [$clog2(DEPTH)-1:0]   raddr_i,
    output fq_entry_t                  rdata_o
);

    fq_entry_t mem_q [DEPTH];

    // Write the incoming entry on the rising edge.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/atomrvcore_fetch_queue.sv
// Instruction fetch queue between fetch and decode.
// Optional feature: define ATOMRVCORE_FQ_BYPASS_EN to forward an incoming pair
// straight to decode when the queue is empty (zero-cycle latency).
module atomrvcore_fetch_queue
    import atomrvcore_pkg::*;
#(
    // Must match the entry width in atomrvcore_pkg.
    parameter int unsigned DATAWIDTH = FQ_DATAWIDTH,
    // Power of two, at least 2, so the pointers wrap naturally.
    parameter int unsigned DEPTH     = FQ_DEPTH_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    atomrvcore_fetch_queue_if.slave  fq
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [PtrW-1:0]      rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]      count_q, count_d;
    logic                 empty, full;
    logic                 push_req, write, pop, bypass;
    logic [DATAWIDTH-1:0] head_pc, head_instr;
    fq_entry_t            wdata, rdata;

    assign wdata.pc    = fq.PC_i;
    assign wdata.instr = fq.instruction_i;

    atomrvcore_fq_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (write),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    // Handshake decode; ready depends on registered occupancy only.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CntW'(DEPTH));
        push_req = fq.valid_i & ~full & ~fq.flush_i;
`ifdef ATOMRVCORE_FQ_BYPASS_EN
        bypass   = empty & fq.valid_i & ~fq.flush_i;
`else
        bypass   = 1'b0;
`endif
        // A bypassed pair taken by decode this cycle is never stored.
        write    = push_req & ~(bypass & fq.ready_i);
        // Pops only move rd_ptr when a stored entry is at the head.
        pop      = ~empty & fq.ready_i & ~fq.flush_i;
    end

    // Occupancy next state: both or neither leaves count unchanged.
    always_comb begin
        count_d = count_q;
        if (write && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !write) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Head selection; stored entries take priority over the bypass path.
    always_comb begin
        head_pc    = '0;
        head_instr = '0;
        if (!empty) begin
            head_pc    = rdata.pc;
            head_instr = rdata.instr;
        end else if (bypass) begin
            head_pc    = fq.PC_i;
            head_instr = fq.instruction_i;
        end
    end

    assign fq.ready_o       = ~full;
    assign fq.valid_o       = ~empty | bypass;
    assign fq.PC_o          = head_pc;
    assign fq.instruction_o = head_instr;
    assign fq.count_o       = count_q;

    // Pointer and count state; reset beats flush, flush beats push/pop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (fq.flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (write) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_atomrvcore_fetch_queue.sv
// Self-checking bench for atomrvcore_fetch_queue against a queue-based model.
module tb_atomrvcore_fetch_queue;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
`ifdef ATOMRVCORE_FQ_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    atomrvcore_fetch_queue_if #(.DATAWIDTH(DW), .DEPTH(DEPTH)) fq_if ();

    atomrvcore_fetch_queue #(
        .DATAWIDTH (DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .fq    (fq_if)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int n_pops   = 0;

    // Model: each entry is {pc, instr}, head at index 0.
    logic [63:0] q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, then advance the model.
    task automatic cycle(input bit v, input logic [31:0] pc, input bit rdy, input bit fl,
                         input bit rs);
        logic [31:0] ins;
        bit          empty, full, byp, exp_valid, push_ok;
        logic [31:0] exp_pc, exp_ins;
        ins = 32'h0000_0013 + pc;
        @(negedge clk);
        rst_i               = rs;
        fq_if.valid_i       = v;
        fq_if.PC_i          = pc;
        fq_if.instruction_i = ins;
        fq_if.ready_i       = rdy;
        fq_if.flush_i       = fl;
        #1;
        empty     = (q.size() == 0);
        full      = (q.size() == DEPTH);
        byp       = Byp && empty && v && !fl;
        exp_valid = !empty || byp;
        exp_pc    = !empty ? q[0][63:32] : (byp ? pc : 32'h0);
        exp_ins   = !empty ? q[0][31:0]  : (byp ? ins : 32'h0);
        chk("count", 32'(fq_if.count_o), 32'(q.size()));
        chk("ready", 32'(fq_if.ready_o), 32'(!full));
        chk("valid", 32'(fq_if.valid_o), 32'(exp_valid));
        chk("pc", fq_if.PC_o, exp_pc);
        chk("instr", fq_if.instruction_o, exp_ins);
        @(posedge clk);
        push_ok = v && !full;
        if (rs || fl) begin
            q.delete();
        end else begin
            if (exp_valid && rdy) n_pops++;
            if (!(byp && rdy)) begin
                if (!empty && rdy) void'(q.pop_front());
                if (push_ok) q.push_back({pc, ins});
            end
        end
    endtask

    initial begin
        rst_i               = 1'b1;
        fq_if.valid_i       = 1'b0;
        fq_if.PC_i          = '0;
        fq_if.instruction_i = '0;
        fq_if.ready_i       = 1'b0;
        fq_if.flush_i       = 1'b0;
        @(posedge clk);

        // Reset then idle.
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Fill with decode stalled; the fifth push must be ignored.
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'(4 * i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Streaming.
        for (int i = 0; i < 20; i++) cycle(1'b1, 32'h1000 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Wrap-around with random decode stalls.
        for (int i = 0; i < 10; i++)
            cycle(1'b1, 32'h2000 + 32'(4 * i), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush with three queued entries and a concurrent push of 0x100.
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h100, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Reset mid-operation with a full queue.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h400 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h500, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Random traffic with occasional flushes and resets.
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 3) != 0), $urandom & 32'hFFFF_FFFC,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 63) == 0));
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("drained", 32'(fq_if.count_o), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
